// File: rtl/countdown_timer_pkg.sv
// Shared types and defaults for the countdown timer and its prescaler.
package countdown_timer_pkg;

   localparam int DEF_WIDTH = 4;
   localparam int DEF_PRE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2,
      DONE = 2'd3
   } state_e;

endpackage

// File: rtl/countdown_timer_prescaler.sv
// Divides clk into ticks: one tick every prescale+1 enabled cycles.
module tick_prescaler
   import countdown_timer_pkg::*;
#(
   parameter int PRE_W = DEF_PRE_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             enable,
   input  logic [PRE_W-1:0] prescale,
   output logic             tick
);

   logic [PRE_W-1:0] cnt_q;

   // >= so that lowering prescale below the current phase ticks at once
   assign tick = enable && (cnt_q >= prescale);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (enable) begin
         cnt_q <= tick ? '0 : cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/countdown_timer.sv
// Loadable countdown timer with pause, one-shot/periodic modes and a prescaler.
// Handshake: none; load_en/start/pause are sampled every edge, load_en > start > pause.
module countdown_timer
   import countdown_timer_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int PRE_W = DEF_PRE_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_en,
   input  logic [WIDTH-1:0] load_val,
   input  logic             start,
   input  logic             pause,
   input  logic             auto_reload,
   input  logic [PRE_W-1:0] prescale,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             expired,
   output state_e           dbg_state
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             pend_q, pend_d;
   logic             busy_q, expired_q;
   logic             pre_clear, pre_en, tick;

   tick_prescaler #(.PRE_W(PRE_W)) u_prescaler (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (pre_clear),
      .enable   (pre_en),
      .prescale (prescale),
      .tick     (tick)
   );

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      reload_d  = reload_q;
      pend_d    = 1'b0;
      pre_clear = 1'b0;
      pre_en    = 1'b0;
      if (load_en) begin
         reload_d  = load_val;
         count_d   = load_val;
         pre_clear = 1'b1;
         state_d   = IDLE;
      end else if (start && (state_q == IDLE || state_q == DONE)) begin
         pre_clear = 1'b1;
         count_d   = reload_q;
         if (reload_q == '0) begin
            state_d = DONE;
            pend_d  = 1'b1;
         end else begin
            state_d = RUN;
         end
      end else if (pause && state_q == RUN) begin
         state_d = HOLD;
      end else if (!pause && state_q == HOLD) begin
         state_d = RUN;
      end else if (state_q == RUN) begin
         pre_en = 1'b1;
         if (tick) begin
            // terminal count: expired follows one cycle after count reaches 0/reload
            if (count_q > 1) begin
               count_d = count_q - 1'b1;
            end else if (auto_reload) begin
               count_d = reload_q;
               pend_d  = 1'b1;
            end else begin
               count_d = '0;
               state_d = DONE;
               pend_d  = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         count_q   <= '0;
         reload_q  <= '0;
         pend_q    <= 1'b0;
         busy_q    <= 1'b0;
         expired_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         reload_q  <= reload_d;
         pend_q    <= pend_d;
         busy_q    <= (state_d == RUN) || (state_d == HOLD);
         expired_q <= load_en ? 1'b0 : pend_q;
      end
   end

   assign count     = count_q;
   assign busy      = busy_q;
   assign expired   = expired_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: per-cycle model check plus literal expectations.
module tb_countdown_timer;
   import countdown_timer_pkg::*;

   localparam int W = 4;
   localparam int P = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         load_en = 1'b0;
   logic [W-1:0] load_val = '0;
   logic         start = 1'b0;
   logic         pause = 1'b0;
   logic         auto_reload = 1'b0;
   logic [P-1:0] prescale = '0;
   logic [W-1:0] count;
   logic         busy;
   logic         expired;
   state_e       dbg_state;

   int n_vec = 0;
   int n_err = 0;
   bit checking = 1'b1;

   countdown_timer #(.WIDTH(W), .PRE_W(P)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_en     (load_en),
      .load_val    (load_val),
      .start       (start),
      .pause       (pause),
      .auto_reload (auto_reload),
      .prescale    (prescale),
      .count       (count),
      .busy        (busy),
      .expired     (expired),
      .dbg_state   (dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // behavioural model: timer described as elapsed-cycle accounting
   state_e       m_state;
   int           m_count, m_reload, m_elapsed;
   bit           m_pend, m_exp, m_was_pend;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_state = IDLE; m_count = 0; m_reload = 0; m_elapsed = 0;
         m_pend = 0; m_exp = 0;
      end else begin
         m_was_pend = m_pend;
         m_pend = 0;
         m_exp = load_en ? 1'b0 : m_was_pend;
         if (load_en) begin
            m_reload = int'(load_val); m_count = m_reload; m_elapsed = 0; m_state = IDLE;
         end else if (start && (m_state == IDLE || m_state == DONE)) begin
            m_elapsed = 0;
            m_count = m_reload;
            if (m_reload == 0) begin m_state = DONE; m_pend = 1; end
            else m_state = RUN;
         end else if (m_state == RUN && pause) begin
            m_state = HOLD;
         end else if (m_state == HOLD && !pause) begin
            m_state = RUN;
         end else if (m_state == RUN) begin
            m_elapsed = m_elapsed + 1;
            if (m_elapsed > int'(prescale)) begin
               m_elapsed = 0;
               if (m_count >= 2) m_count = m_count - 1;
               else begin
                  m_pend = 1;
                  if (auto_reload) m_count = m_reload;
                  else begin m_count = 0; m_state = DONE; end
               end
            end
         end
      end
   end

   // scoreboard compare, 1 time unit after every active edge
   always @(posedge clk) begin
      #1;
      if (checking) begin
         chk("cyc_count", 32'(count), 32'(m_count));
         chk("cyc_busy", 32'(busy), 32'(m_state == RUN || m_state == HOLD));
         chk("cyc_expired", 32'(expired), 32'(m_exp));
         chk("cyc_state", 32'(dbg_state), 32'(m_state));
      end
   end

   // driver: advance to just after an edge; inputs set here are stable for the next edge
   task automatic next_cycle(input int n = 1);
      repeat (n) @(posedge clk);
      #2;
   endtask

   int ar_cnt[7] = '{3, 2, 2, 1, 1, 3, 3};

   initial begin
      // reset state
      next_cycle(2);
      chk("rst_count", 32'(count), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_expired", 32'(expired), 0);
      chk("rst_state", 32'(dbg_state), 32'(IDLE));
      rst_n = 1'b1;

      // load 4, one-shot, prescale 0
      load_val = 4; load_en = 1; next_cycle();
      chk("load_count", 32'(count), 4);
      chk("load_state", 32'(dbg_state), 32'(IDLE));
      load_en = 0; start = 1; next_cycle();
      chk("start_count", 32'(count), 4);
      chk("start_busy", 32'(busy), 1);
      start = 0;
      for (int i = 3; i >= 0; i--) begin
         next_cycle();
         chk("os_count", 32'(count), 32'(i));
         chk("os_exp_early", 32'(expired), 0);
      end
      chk("os_state", 32'(dbg_state), 32'(DONE));
      chk("os_busy", 32'(busy), 0);
      next_cycle();
      chk("os_expired", 32'(expired), 1);
      chk("os_hold0", 32'(count), 0);
      next_cycle();
      chk("os_exp_once", 32'(expired), 0);

      // auto-reload, load 3, prescale 1: period 6
      load_val = 3; load_en = 1; prescale = 1; auto_reload = 1; next_cycle();
      load_en = 0; start = 1; next_cycle();
      chk("ar_start", 32'(count), 3);
      start = 0;
      for (int i = 1; i <= 13; i++) begin
         next_cycle();
         if (i <= 7) chk("ar_count", 32'(count), 32'(ar_cnt[i-1]));
         chk("ar_expired", 32'(expired), 32'(i == 7 || i == 13));
         chk("ar_busy", 32'(busy), 1);
      end

      // pause: load 5, run to 3, hold for 7 cycles
      auto_reload = 0; prescale = 0;
      load_val = 5; load_en = 1; next_cycle();
      load_en = 0; start = 1; next_cycle();
      start = 0; next_cycle(2);
      chk("pz_pre", 32'(count), 3);
      pause = 1;
      for (int i = 0; i < 7; i++) begin
         next_cycle();
         chk("pz_count", 32'(count), 3);
         chk("pz_busy", 32'(busy), 1);
      end
      pause = 0; next_cycle();
      chk("pz_resume", 32'(count), 3);
      next_cycle(3);
      chk("pz_zero", 32'(count), 0);
      chk("pz_noexp", 32'(expired), 0);
      next_cycle();
      chk("pz_expired", 32'(expired), 1);

      // simultaneous load/start/pause while running
      prescale = 2; load_val = 6; load_en = 1; next_cycle();
      load_en = 0; start = 1; next_cycle(4);
      start = 0;
      load_val = 9; load_en = 1; start = 1; pause = 1; next_cycle();
      chk("sim_count", 32'(count), 9);
      chk("sim_state", 32'(dbg_state), 32'(IDLE));
      chk("sim_busy", 32'(busy), 0);
      load_en = 0; start = 0; pause = 0; next_cycle();
      chk("sim_nodec", 32'(count), 9);

      // zero reload
      load_val = 0; load_en = 1; next_cycle();
      load_en = 0; start = 1; next_cycle();
      start = 0;
      chk("z_state", 32'(dbg_state), 32'(DONE));
      chk("z_count", 32'(count), 0);
      chk("z_noexp", 32'(expired), 0);
      next_cycle();
      chk("z_expired", 32'(expired), 1);
      next_cycle();
      chk("z_single", 32'(expired), 0);

      // reset mid-run at count 5
      prescale = 0; load_val = 8; load_en = 1; next_cycle();
      load_en = 0; start = 1; next_cycle();
      start = 0; next_cycle(3);
      chk("rr_pre", 32'(count), 5);
      rst_n = 0; #1;
      chk("rr_count", 32'(count), 0);
      chk("rr_busy", 32'(busy), 0);
      next_cycle(2);
      rst_n = 1;
      load_val = 2; load_en = 1; next_cycle();
      chk("rr_reload", 32'(count), 2);
      chk("rr_noexp", 32'(expired), 0);
      load_en = 0; auto_reload = 1; start = 1; next_cycle();
      start = 0; next_cycle(6);

      checking = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have parameter WIDTH, default 4: bit width of the count and reload value.
REQ-002 SHALL have parameter PRE_W, default 4: bit width of the prescale divisor.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port load_en, input, 1 bit: load load_val into the reload register and the count.
REQ-006 SHALL have port load_val, input, WIDTH bits: reload value (period, in ticks).
REQ-007 SHALL have port start, input, 1 bit: begin countdown from the reload value.
REQ-008 SHALL have port pause, input, 1 bit: level-sensitive freeze while high.
REQ-009 SHALL have port auto_reload, input, 1 bit: 1 = periodic mode, 0 = one-shot mode.
REQ-010 SHALL have port prescale, input, PRE_W bits: one tick every prescale+1 clk cycles.
REQ-011 SHALL have port count, output, WIDTH bits: current registered count.
REQ-012 SHALL have port busy, output, 1 bit: high in state RUN or HOLD.
REQ-013 SHALL have port expired, output, 1 bit: registered one-cycle terminal-count pulse.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, HOLD, DONE.
REQ-015 SHALL apply input priority per cycle: load_en over start over pause.
REQ-016 load_en in any state SHALL, at the next edge, set reload=count=load_val, clear the prescaler and enter IDLE; expired stays 0.
REQ-017 start in IDLE or DONE SHALL, at the next edge, set count=reload, clear the prescaler and enter RUN.
REQ-018 start in IDLE or DONE with reload==0 SHALL instead enter DONE and pulse expired in the following cycle.
REQ-019 start in RUN or HOLD SHALL be ignored.
REQ-020 In RUN, the prescaler SHALL count 0..prescale; a tick occurs on the cycle it equals prescale, and it then wraps to 0.
REQ-021 prescale=0 SHALL produce a tick every cycle.
REQ-022 A tick in RUN with count>1 SHALL decrement count by 1.
REQ-023 A tick in RUN with count==1 and auto_reload=0 SHALL set count=0, enter DONE and assert expired in the next cycle.
REQ-024 A tick in RUN with count==1 and auto_reload=1 SHALL set count=reload, stay in RUN and assert expired in the next cycle.
REQ-025 Under auto_reload=1, the expired period SHALL be exactly reload*(prescale+1) cycles.
REQ-026 pause=1 in RUN SHALL enter HOLD, freezing count and prescaler; pause=0 in HOLD SHALL return to RUN with nothing lost.
REQ-027 pause SHALL have no effect in IDLE or DONE.
REQ-028 auto_reload and prescale SHALL be sampled every cycle; a change takes effect on the next tick.
REQ-029 count SHALL never underflow or wrap below 0.
REQ-030 DONE SHALL hold count=0 until load_en or start.

Reset
REQ-031 rst_n low SHALL immediately force state=IDLE, count=0, reload=0, prescaler=0, busy=0, expired=0, regardless of clk.
REQ-032 Reset asserted mid-countdown or mid-pulse SHALL abort the operation with no residual expired pulse after release.
REQ-033 After release, the first edge SHALL honour inputs normally.

Structure
REQ-034 A shared package SHALL hold the FSM state enum (IDLE, RUN, HOLD, DONE) and the WIDTH/PRE_W defaults.
REQ-035 The prescaler SHALL be a separate sub-module, tick_prescaler (inputs clk, rst_n, clear, enable, prescale; output tick).
REQ-036 All outputs SHALL be driven from registers.

Verification
REQ-037 Load and count: load_val=4 with load_en for 1 cycle, then start, prescale=0, auto_reload=0 -> count 4,3,2,1,0; expired high exactly 1 cycle after count reaches 0; state DONE; busy low.
REQ-038 Auto-reload with prescale: load 3, prescale=1, auto_reload=1, start -> expired pulses every 6 cycles; count sequence 3,3,2,2,1,1,3...; busy stays high.
REQ-039 Pause: load 5, run to count=3, hold pause for 7 cycles -> count stays 3 and busy stays 1; after release, expired fires 3 ticks later.
REQ-040 Simultaneous inputs: load_en=1, start=1, pause=1 in the same cycle with load_val=9 -> state IDLE, count=9, no decrement.
REQ-041 Zero reload: load 0, start -> DONE, count=0, a single expired pulse.
REQ-042 Reset mid-run: load 8, start, assert rst_n=0 at count=5 between clock edges -> count=0 and busy=0 immediately; no expired pulse after release.
